// File: rtl/preg_freelist_pkg.sv
// Shared constants, range macros and pointer types for the physical-register free list.
// Pointers carry one extra MSB as a wrap bit, so full and empty can be told apart.
`ifndef PREG_FREELIST_PKG_SV
`define PREG_FREELIST_PKG_SV

`define PREG_RANGE 5:0
`define LREG_RANGE 4:0
`define FREELIST_PTR 5:0

package preg_freelist_pkg;
    localparam int PREG_NUM = 64;
    localparam int ARCH_NUM = 32;
    localparam int DEPTH    = PREG_NUM - ARCH_NUM;
    localparam int PREG_W   = $clog2(PREG_NUM);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PTR_W    = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [PTR_W-1:0]  ptr_t;

    function automatic idx_t ptr_idx(input ptr_t p);
        return p[IDX_W-1:0];
    endfunction
endpackage

`endif

// File: rtl/preg_freelist_ptr.sv
// Wrap-bit pointer register: increment enable plus a synchronous load that wins over increment.
module preg_freelist_ptr
    import preg_freelist_pkg::*;
#(
    parameter ptr_t RST_VAL = '0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t value
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= RST_VAL;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            value <= value + ptr_t'(1);
        end
    end

endmodule

// File: rtl/preg_freelist.sv
// Physical-register free list: circular buffer of free pregs with a speculative head
// for rename, an architectural head for commit, and a tail where retired old mappings land.
module preg_freelist
    import preg_freelist_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   alloc_req,
    output logic                   alloc_valid,
    output logic [`PREG_RANGE]     alloc_prd,
    input  logic                   commit,
    input  logic                   commit_alloc,
    input  logic [`PREG_RANGE]     commit_old_prd,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] free_count
);

    preg_t mem [DEPTH];

    ptr_t spec_head;
    ptr_t arch_head;
    ptr_t tail;
    ptr_t spec_cnt;
    ptr_t restore_ptr;
    logic do_alloc;
    logic do_free;

    assign spec_cnt    = tail - spec_head;
    assign alloc_valid = (spec_cnt != '0);
    assign alloc_prd   = mem[ptr_idx(spec_head)];
    assign free_count  = spec_cnt;

    assign do_alloc = alloc_req & alloc_valid & ~flush;
    assign do_free  = commit & commit_alloc;

    // Flush restores to the architectural head as it stands after this cycle's commit.
    assign restore_ptr = arch_head + ptr_t'(do_free);

    preg_freelist_ptr #(.RST_VAL('0)) u_spec_head (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (do_alloc),
        .load     (flush),
        .load_val (restore_ptr),
        .value    (spec_head)
    );

    preg_freelist_ptr #(.RST_VAL('0)) u_arch_head (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (do_free),
        .load     (1'b0),
        .load_val ('0),
        .value    (arch_head)
    );

    preg_freelist_ptr #(.RST_VAL(ptr_t'(DEPTH))) u_tail (
        .clock    (clock),
        .reset_n  (reset_n),
        .inc      (do_free),
        .load     (1'b0),
        .load_val ('0),
        .value    (tail)
    );

    // No bypass: a freed preg is visible at alloc_prd only from the next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= preg_t'(ARCH_NUM + i);
            end
        end else if (do_free) begin
            mem[ptr_idx(tail)] <= commit_old_prd;
        end
    end

endmodule

// File: tb/tb_preg_freelist.sv
// Directed and random bench for preg_freelist against a queue-based model of free/mapped pregs.
module tb_preg_freelist;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_prd;
    logic       commit;
    logic       commit_alloc;
    logic [5:0] commit_old_prd;
    logic       flush;
    logic [5:0] free_count;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: arch_q holds the 32 list entries in order from the architectural head;
    // the first spec_off of them are handed out but not retired. mapped_q holds every
    // other preg (architecturally mapped); the two queues always partition 0..63.
    int arch_q[$];
    int mapped_q[$];
    int spec_off;
    int nfree;

    preg_freelist dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alloc_req      (alloc_req),
        .alloc_valid    (alloc_valid),
        .alloc_prd      (alloc_prd),
        .commit         (commit),
        .commit_alloc   (commit_alloc),
        .commit_old_prd (commit_old_prd),
        .flush          (flush),
        .free_count     (free_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        arch_q.delete();
        mapped_q.delete();
        for (int i = 0; i < 32; i++) begin
            arch_q.push_back(32 + i);
            mapped_q.push_back(i);
        end
        spec_off = 0;
        nfree    = 0;
    endtask

    task automatic check_all();
        logic [5:0] occ;
        occ = dut.tail - dut.arch_head;
        check("alloc_valid", 32'(alloc_valid), 32'(spec_off < 32));
        if (spec_off < 32) check("alloc_prd", 32'(alloc_prd), 32'(arch_q[spec_off]));
        check("free_count", 32'(free_count), 32'(32 - spec_off));
        check("count_bound", 32'(free_count <= 6'd32), 32'd1);
        check("occupancy", 32'(occ), 32'd32);
        check("arch_head", 32'(dut.arch_head), 32'(nfree % 64));
        check("spec_head", 32'(dut.spec_head), 32'((nfree + spec_off) % 64));
    endtask

    // Drive one cycle (called just after a falling edge), update the model, check at next fall.
    task automatic step(input logic a, input logic c, input logic ca, input int old, input logic f);
        logic grant;
        int   front;
        int   idx[$];
        alloc_req      = a;
        commit         = c;
        commit_alloc   = ca;
        commit_old_prd = 6'(old);
        flush          = f;
        grant = a && (spec_off < 32) && !f;
        if (grant) begin
            idx = mapped_q.find_first_index with (item == arch_q[spec_off]);
            check("unique_grant", 32'(idx.size()), 32'd0);
        end
        @(posedge clock);
        if (c && ca) begin
            front = arch_q.pop_front();
            arch_q.push_back(old);
            idx = mapped_q.find_first_index with (item == old);
            if (idx.size() > 0) mapped_q.delete(idx[0]);
            mapped_q.push_back(front);
            spec_off--;
            nfree++;
        end
        if (grant) spec_off++;
        if (f) spec_off = 0;
        @(negedge clock);
        alloc_req = 0; commit = 0; commit_alloc = 0; flush = 0;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        alloc_req = 0; commit = 0; commit_alloc = 0; commit_old_prd = '0; flush = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_all();
    endtask

    initial begin
        int k;
        logic a, c, f;
        int old;

        // 1: drain the list in order
        do_reset();
        check("reset_prd", 32'(alloc_prd), 32'd32);
        for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0);
        check("empty_valid", 32'(alloc_valid), 32'd0);
        check("empty_count", 32'(free_count), 32'd0);

        // 2: free into an empty list with a same-cycle request: no bypass
        step(1, 1, 1, 5, 0);
        check("nobypass_prd", 32'(alloc_prd), 32'd5);
        step(1, 0, 0, 0, 0);
        check("after_grant_count", 32'(free_count), 32'd0);
        step(1, 0, 1, 6, 0);          // commit_alloc without commit changes nothing
        step(1, 1, 0, 7, 0);          // commit without commit_alloc changes nothing

        // 3: three allocs, one commit, then flush
        do_reset();
        repeat (3) step(1, 0, 0, 0, 0);
        step(0, 1, 1, 7, 0);
        step(0, 0, 0, 0, 1);
        check("flush_prd", 32'(alloc_prd), 32'd33);
        check("flush_arch_head", 32'(dut.arch_head), 32'd1);
        check("tail_entry", 32'(dut.mem[0]), 32'd7);

        // 4: flush, commit and request in the same cycle
        do_reset();
        repeat (5) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 3, 1);
        check("flush_commit_count", 32'(free_count), 32'd32);
        check("flush_commit_head", 32'(dut.spec_head), 32'd1);

        // Simultaneous alloc and free with one entry left
        do_reset();
        repeat (31) step(1, 0, 0, 0, 0);
        step(1, 1, 1, 9, 0);
        check("cnt1_count", 32'(free_count), 32'd1);
        check("cnt1_prd", 32'(alloc_prd), 32'd9);

        // 5: random traffic
        do_reset();
        for (int i = 0; i < 200; i++) begin
            a = ($urandom_range(3) != 0);
            c = (spec_off > 0) && ($urandom_range(1) == 1);
            f = ($urandom_range(15) == 0);
            k = $urandom_range(mapped_q.size() - 1);
            old = mapped_q[k];
            step(a, c, c, old, f);
        end
        check("wrapped", 32'(nfree >= 64), 32'd1);

        // 6: asynchronous reset in the middle of an allocation burst
        repeat (4) step(1, 0, 0, 0, 0);
        alloc_req = 1;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_prd", 32'(alloc_prd), 32'd32);
        check("async_count", 32'(free_count), 32'd32);
        check("async_valid", 32'(alloc_valid), 32'd1);
        alloc_req = 0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check_all();
        step(1, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
